// File: rtl/dff_delay_line.sv
// dff_delay_line: stallable WIDTH-bit + valid delay line with a runtime-selectable
// output tap (1..MAX_DEPTH), used to match pipeline skew in the FFT datapath.
// Besides the data path it tracks how many valid samples sit in the active stages
// (occ) and whether the active stages have been completely refilled since the last
// flush (primed).
module dff_delay_line #(
  parameter int WIDTH     = 16,
  parameter int MAX_DEPTH = 8,
  parameter int DSW       = $clog2(MAX_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             cfg_load,
  input  logic [DSW-1:0]   cfg_depth,
  input  logic             clr,
  input  logic             en,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data,
  output logic [DSW-1:0]   depth,
  output logic [DSW-1:0]   occ,
  output logic             primed
);

  // Requested depth forced into 1..MAX_DEPTH; a depth of 0 would leave no tap.
  function automatic logic [DSW-1:0] clamp_depth(input logic [DSW-1:0] req);
    logic [DSW-1:0] res;
    if (req == {DSW{1'b0}}) begin
      res = DSW'(1);
    end else if (req > DSW'(MAX_DEPTH)) begin
      res = DSW'(MAX_DEPTH);
    end else begin
      res = req;
    end
    return res;
  endfunction

  logic [WIDTH-1:0]     d_r [MAX_DEPTH];
  logic [MAX_DEPTH-1:0] v_r;
  logic [DSW-1:0]       depth_r;
  logic [DSW-1:0]       occ_r;
  logic [DSW-1:0]       prime_cnt_r;

  logic                 tap_vld_s;
  logic [WIDTH-1:0]     tap_data_s;
  logic                 flush_s;

  // Any of these empties the line; reset additionally restores the default depth.
  assign flush_s = cfg_load | clr;

  // Tap mux: select stage depth_r-1 (registers only, no path from the inputs).
  always_comb begin
    tap_vld_s  = 1'b0;
    tap_data_s = {WIDTH{1'b0}};
    for (int i = 0; i < MAX_DEPTH; i++) begin
      tap_vld_s  = (depth_r == DSW'(i + 1)) ? v_r[i] : tap_vld_s;
      tap_data_s = (depth_r == DSW'(i + 1)) ? d_r[i] : tap_data_s;
    end
  end

  // Data stages: zeroed on reset/flush, shifted on enable, held on stall.
  always_ff @(posedge clk) begin
    if (!rstb || flush_s) begin
      for (int i = 0; i < MAX_DEPTH; i++) begin
        d_r[i] <= {WIDTH{1'b0}};
      end
    end else if (en) begin
      d_r[0] <= in_data;
      for (int i = 1; i < MAX_DEPTH; i++) begin
        d_r[i] <= d_r[i-1];
      end
    end else begin
      for (int i = 0; i < MAX_DEPTH; i++) begin
        d_r[i] <= d_r[i];
      end
    end
  end

  // Control state: valid bits, active depth, occupancy and prime counter.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      v_r         <= {MAX_DEPTH{1'b0}};
      depth_r     <= DSW'(MAX_DEPTH);
      occ_r       <= {DSW{1'b0}};
      prime_cnt_r <= {DSW{1'b0}};
    end else if (cfg_load) begin
      v_r         <= {MAX_DEPTH{1'b0}};
      depth_r     <= clamp_depth(cfg_depth);
      occ_r       <= {DSW{1'b0}};
      prime_cnt_r <= {DSW{1'b0}};
    end else if (clr) begin
      v_r         <= {MAX_DEPTH{1'b0}};
      occ_r       <= {DSW{1'b0}};
      prime_cnt_r <= {DSW{1'b0}};
    end else if (en) begin
      v_r <= {v_r[MAX_DEPTH-2:0], in_vld};
      // A valid entering stage 0 and a valid leaving the tap cancel each other.
      case ({in_vld, tap_vld_s})
        2'b10:   occ_r <= occ_r + DSW'(1);
        2'b01:   occ_r <= occ_r - DSW'(1);
        default: occ_r <= occ_r;
      endcase
      // prime_cnt never exceeds depth_r because every depth change also clears it.
      if (prime_cnt_r == depth_r) begin
        prime_cnt_r <= prime_cnt_r;
      end else begin
        prime_cnt_r <= prime_cnt_r + DSW'(1);
      end
    end else begin
      v_r         <= v_r;
      occ_r       <= occ_r;
      prime_cnt_r <= prime_cnt_r;
    end
  end

  assign out_vld  = tap_vld_s;
  assign out_data = tap_vld_s ? tap_data_s : {WIDTH{1'b0}};
  assign depth    = depth_r;
  assign occ      = occ_r;
  assign primed   = (prime_cnt_r == depth_r);

endmodule

// File: tb/tb_dff_delay_line.sv
// Self-checking bench for dff_delay_line: directed scenarios plus random stimulus,
// all compared against a history-queue reference model.
module tb_dff_delay_line;

  localparam int WIDTH     = 16;
  localparam int MAX_DEPTH = 8;
  localparam int DSW       = $clog2(MAX_DEPTH + 1);

  logic             clk;
  logic             rstb;
  logic             cfg_load;
  logic [DSW-1:0]   cfg_depth;
  logic             clr;
  logic             en;
  logic             in_vld;
  logic [WIDTH-1:0] in_data;
  logic             out_vld;
  logic [WIDTH-1:0] out_data;
  logic [DSW-1:0]   depth;
  logic [DSW-1:0]   occ;
  logic             primed;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: accepted samples since the last flush, newest first, as {vld,data}.
  logic [WIDTH:0] hist[$];
  int             mdepth;

  dff_delay_line #(.WIDTH(WIDTH), .MAX_DEPTH(MAX_DEPTH)) dut (
    .clk(clk), .rstb(rstb), .cfg_load(cfg_load), .cfg_depth(cfg_depth), .clr(clr),
    .en(en), .in_vld(in_vld), .in_data(in_data), .out_vld(out_vld), .out_data(out_data),
    .depth(depth), .occ(occ), .primed(primed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model by the same rules, compare at negedge.
  task automatic step(input logic r, input logic ld, input logic [DSW-1:0] cd,
                      input logic c, input logic e, input logic v, input logic [WIDTH-1:0] dat);
    int             exp_occ;
    logic           exp_vld;
    logic [WIDTH:0] tap;
    rstb = r; cfg_load = ld; cfg_depth = cd; clr = c; en = e; in_vld = v; in_data = dat;
    @(posedge clk);
    if (!r) begin
      mdepth = MAX_DEPTH;
      hist.delete();
    end else if (ld) begin
      mdepth = (cd == 0) ? 1 : ((int'(cd) > MAX_DEPTH) ? MAX_DEPTH : int'(cd));
      hist.delete();
    end else if (c) begin
      hist.delete();
    end else if (e) begin
      hist.push_front({v, dat});
      if (hist.size() > MAX_DEPTH) void'(hist.pop_back());
    end
    @(negedge clk);
    exp_occ = 0;
    for (int i = 0; i < hist.size() && i < mdepth; i++) exp_occ += int'(hist[i][WIDTH]);
    tap     = (hist.size() >= mdepth) ? hist[mdepth-1] : '0;
    exp_vld = tap[WIDTH];
    check_eq("out_vld", 32'(out_vld), 32'(exp_vld));
    check_eq("out_data", 32'(out_data), exp_vld ? 32'(tap[WIDTH-1:0]) : 32'd0);
    check_eq("depth", 32'(depth), 32'(mdepth));
    check_eq("occ", 32'(occ), 32'(exp_occ));
    check_eq("primed", 32'(primed), (hist.size() >= mdepth) ? 32'd1 : 32'd0);
  endtask

  task automatic shift(input logic v, input logic [WIDTH-1:0] dat);
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, v, dat);
  endtask

  task automatic load(input logic [DSW-1:0] d);
    step(1'b1, 1'b1, d, 1'b0, 1'b0, 1'b0, 16'd0);
  endtask

  initial begin
    logic [4:0] pat;
    mdepth = MAX_DEPTH;
    rstb = 1'b0; cfg_load = 1'b0; cfg_depth = 4'd0; clr = 1'b0;
    en = 1'b0; in_vld = 1'b0; in_data = 16'd0;
    @(negedge clk);

    // T1: reset held two cycles with traffic on the inputs
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 16'h1234);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 16'h5678);
    check_eq("t1_out_vld", 32'(out_vld), 32'd0);
    check_eq("t1_out_data", 32'(out_data), 32'd0);
    check_eq("t1_depth", 32'(depth), 32'd8);
    check_eq("t1_occ", 32'(occ), 32'd0);
    check_eq("t1_primed", 32'(primed), 32'd0);

    // T2: depth 4 latency
    load(4'd4);
    for (int k = 1; k <= 8; k++) begin
      shift(1'b1, 16'(k));
      if (k == 3) check_eq("t2_not_primed", 32'(primed), 32'd0);
      if (k == 4) begin
        check_eq("t2_first_out", 32'(out_data), 32'd1);
        check_eq("t2_primed", 32'(primed), 32'd1);
      end
      if (k >= 4) check_eq("t2_occ", 32'(occ), 32'd4);
    end

    // T3: three stall cycles mid-stream
    for (int k = 9; k <= 10; k++) shift(1'b1, 16'(k));
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 16'hdead);
    check_eq("t3_frozen", 32'(out_data), 32'd7);
    for (int k = 11; k <= 16; k++) shift(1'b1, 16'(k));

    // T4: clamping and reload mid-stream
    load(4'd0);
    check_eq("t4_clamp_lo", 32'(depth), 32'd1);
    shift(1'b1, 16'h00aa);
    check_eq("t4_lat1", 32'(out_data), 32'h00aa);
    load(4'd15);
    check_eq("t4_clamp_hi", 32'(depth), 32'd8);
    for (int k = 0; k < 5; k++) shift(1'b1, 16'(16'h0100 + k));
    load(4'd3);
    check_eq("t4_reload_occ", 32'(occ), 32'd0);
    for (int k = 0; k < 4; k++) shift(1'b1, 16'(16'h0200 + k));

    // T5: priorities
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 16'haaaa);
    check_eq("t5_clr_occ", 32'(occ), 32'd0);
    step(1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 1'b1, 16'h5555);
    check_eq("t5_load_over_clr", 32'(depth), 32'd5);
    step(1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 1'b1, 16'h7777);
    check_eq("t5_rst_over_load", 32'(depth), 32'd8);

    // T6: bubbles at depth 3
    load(4'd3);
    pat = 5'b01101;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 5; k++) shift(pat[k], 16'(16'h0300 + r * 8 + k));

    // Random traffic with occasional reset, reload, flush and stall
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 29) == 0),
           DSW'($urandom_range(0, 15)), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7),
           WIDTH'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
